// File: rtl/systolic_skew_feeder.sv
// Input stage for the 8x8 1-bit systolic array: buffers row vectors in a small
// FIFO and releases each one diagonally skewed so its wavefront enters aligned.

module systolic_skew_feeder #(
  parameter int LANES = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LANES-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             start,
  input  logic             flush,
  output logic [LANES-1:0] sys_out,
  output logic [LANES-1:0] out_tag,
  output logic             busy,
  output logic             done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t           state_r;
  logic             busy_r;
  logic             done_r;
  logic [LANES-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  logic             ready_s;
  logic             push_s;
  logic             pop_s;
  logic             drain_done_s;
  logic [LANES-1:0] stage0_dat_s;
  logic [LANES-1:0] inner_tag_s;

  // Ready never reopens on a same-cycle pop: no bypass path from pop to push.
  always_comb begin
    ready_s = 1'b0;
    if (rst) begin
      ready_s = 1'b0;
    end else if ((count_r < CNT_W'(DEPTH)) && (state_r != S_DRAIN)) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
  end

  // Pop decision, head word into stage 0 of every lane, and drain completion.
  always_comb begin
    pop_s        = 1'b0;
    stage0_dat_s = '0;
    drain_done_s = 1'b0;
    if (((state_r == S_STREAM) || (state_r == S_DRAIN)) && (count_r != '0)) begin
      pop_s        = 1'b1;
      stage0_dat_s = mem_r[rd_ptr_r];
    end else begin
      pop_s        = 1'b0;
      stage0_dat_s = '0;
    end
    // Only final stages may still be occupied: after this edge the tags read all-zero.
    if (!pop_s && (inner_tag_s == '0)) begin
      drain_done_s = 1'b1;
    end else begin
      drain_done_s = 1'b0;
    end
  end

  assign push_s   = in_valid && ready_s;
  assign in_ready = ready_s;
  assign busy     = busy_r;
  assign done     = done_r;

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  // FIFO pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Control FSM with registered busy/done so both change together with state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (flush) begin
            state_r <= S_DRAIN;
            busy_r  <= 1'b1;
          end else if (start) begin
            state_r <= S_STREAM;
            busy_r  <= 1'b1;
          end else begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
          end
        end
        S_STREAM: begin
          if (flush) begin
            state_r <= S_DRAIN;
          end else begin
            state_r <= S_STREAM;
          end
        end
        S_DRAIN: begin
          if (drain_done_s) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            state_r <= S_DRAIN;
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Lane j is a chain of j+1 stages; the last stage drives the array column.
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [j:0] dat_r;
    logic [j:0] tag_r;

    if (j == 0) begin : g_head
      // Single-stage lane: loads the popped bit or a bubble every edge.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dat_r <= 1'b0;
          tag_r <= 1'b0;
        end else begin
          dat_r <= stage0_dat_s[0];
          tag_r <= pop_s;
        end
      end
      assign inner_tag_s[0] = 1'b0;
    end else begin : g_chain
      // Multi-stage lane: shifts every edge regardless of state.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dat_r <= '0;
          tag_r <= '0;
        end else begin
          dat_r <= {dat_r[j-1:0], stage0_dat_s[j]};
          tag_r <= {tag_r[j-1:0], pop_s};
        end
      end
      assign inner_tag_s[j] = |tag_r[j-1:0];
    end

    assign sys_out[j] = dat_r[j];
    assign out_tag[j] = tag_r[j];
  end

  // Occupancy must never exceed capacity.
  always @(posedge clk) begin
    if (!rst) begin
      assert (count_r <= CNT_W'(DEPTH));
    end
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Randomized and directed bench for systolic_skew_feeder against a queue-and-
// timeline reference model of the feeder's observable behaviour.

module tb_systolic_skew_feeder;

  localparam int LANES = 8;
  localparam int DEPTH = 4;
  localparam int TL    = 16384;

  logic             clk = 1'b0;
  logic             rst;
  logic [LANES-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             start;
  logic             flush;
  logic [LANES-1:0] sys_out;
  logic [LANES-1:0] out_tag;
  logic             busy;
  logic             done;

  always #5 clk = ~clk;

  systolic_skew_feeder #(.LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .start    (start),
    .flush    (flush),
    .sys_out  (sys_out),
    .out_tag  (out_tag),
    .busy     (busy),
    .done     (done)
  );

  typedef enum {M_IDLE, M_STREAM, M_DRAIN} mst_t;

  int               n_vec = 0;
  int               n_err = 0;
  mst_t             mst;
  logic [LANES-1:0] mq[$];
  logic [LANES-1:0] exp_dat [TL];
  logic [LANES-1:0] exp_tag [TL];
  int               e;
  bit               exp_done;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, e);
    end
  endtask

  // Reference: a word popped at edge p is visible on lane j right after edge p+j.
  task automatic model_edge();
    bit               rdy;
    bit               push;
    bit               pop;
    bit               quiet;
    logic [LANES-1:0] w;
    e++;
    exp_done = 1'b0;
    if (rst) begin
      mq.delete();
      mst = M_IDLE;
      for (int i = e; i < e + 16; i++) begin
        exp_dat[i] = '0;
        exp_tag[i] = '0;
      end
    end else begin
      rdy  = (mq.size() < DEPTH) && (mst != M_DRAIN);
      push = in_valid && rdy;
      pop  = (mst != M_IDLE) && (mq.size() > 0);
      if (pop) begin
        w = mq.pop_front();
        for (int j = 0; j < LANES; j++) begin
          exp_tag[e + j][j] = 1'b1;
          exp_dat[e + j][j] = w[j];
        end
      end
      if (push) mq.push_back(in_data);
      quiet = 1'b1;
      for (int i = e; i <= e + LANES; i++) begin
        if (exp_tag[i] != '0) quiet = 1'b0;
      end
      case (mst)
        M_IDLE:   if (flush) mst = M_DRAIN; else if (start) mst = M_STREAM;
        M_STREAM: if (flush) mst = M_DRAIN;
        M_DRAIN:  if (!pop && quiet) begin mst = M_IDLE; exp_done = 1'b1; end
        default:  mst = M_IDLE;
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("sys_out", 32'(sys_out), 32'(exp_dat[e]));
    check_eq("out_tag", 32'(out_tag), 32'(exp_tag[e]));
    check_eq("done", 32'(done), 32'(exp_done));
    check_eq("busy", 32'(busy), 32'(mst != M_IDLE));
    check_eq("in_ready", 32'(in_ready), 32'(!rst && (mq.size() < DEPTH) && (mst != M_DRAIN)));
    @(negedge clk);
  endtask

  task automatic go_idle();
    int k;
    flush = 1'b1;
    step();
    flush = 1'b0;
    k = 0;
    while (busy && k < 30) begin
      step();
      k++;
    end
    check_eq("idle_reached", 32'(busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < TL; i++) begin
      exp_dat[i] = '0;
      exp_tag[i] = '0;
    end
    e = 0; mst = M_IDLE; exp_done = 1'b0;
    rst = 1'b1; in_data = '0; in_valid = 1'b0; start = 1'b0; flush = 1'b0;
    @(negedge clk);
    step(); step();
    rst = 1'b0;
    step();
    check_eq("ready_after_reset", 32'(in_ready), 32'd1);

    // single wavefront: push at edge 0, start at edge 1, pop at edge 2
    in_data = 8'hFF; in_valid = 1'b1; step();
    in_valid = 1'b0; start = 1'b1; step();
    start = 1'b0;
    for (int j = 0; j < LANES; j++) begin
      step();
      check_eq("wave_dat", 32'(sys_out), 32'(8'h01 << j));
      check_eq("wave_tag", 32'(out_tag), 32'(8'h01 << j));
    end
    step();
    check_eq("wave_clear", 32'(out_tag), 32'd0);
    go_idle();

    // diagonal order
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(8'h01 << i); in_valid = 1'b1; step();
    end
    in_valid = 1'b0; start = 1'b1; step(); start = 1'b0;
    step();
    check_eq("diag_w0", 32'({sys_out[0], out_tag[0]}), 32'd3);
    for (int i = 1; i < 4; i++) begin
      step();
      check_eq("diag_wn", 32'({sys_out[0], out_tag[0]}), 32'd1);
    end
    repeat (10) step();
    go_idle();

    // backpressure
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(8'hA0 + i); in_valid = 1'b1; step();
    end
    check_eq("bp_full", 32'(in_ready), 32'd0);
    in_data = 8'hA4; step();
    check_eq("bp_held", 32'(in_ready), 32'd0);
    start = 1'b1; step(); start = 1'b0;
    step();
    check_eq("bp_reopen", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    repeat (14) step();
    go_idle();

    // flush with two words queued
    in_data = 8'h5A; in_valid = 1'b1; step();
    in_data = 8'hC3; step();
    in_valid = 1'b0; start = 1'b1; step(); start = 1'b0;
    flush = 1'b1; step(); flush = 1'b0;
    check_eq("drain_ready", 32'(in_ready), 32'd0);
    for (int k = 0; k < 8; k++) begin
      step();
      check_eq("done_early", 32'(done), 32'd0);
    end
    step();
    check_eq("done_pulse", 32'(done), 32'd1);
    check_eq("done_idle", 32'(busy), 32'd0);
    step();
    check_eq("done_once", 32'(done), 32'd0);

    // empty flush, then simultaneous start+flush
    flush = 1'b1; step(); flush = 1'b0;
    check_eq("eflush_busy", 32'(busy), 32'd1);
    step();
    check_eq("eflush_done", 32'(done), 32'd1);
    check_eq("eflush_idle", 32'(busy), 32'd0);
    start = 1'b1; flush = 1'b1; step(); start = 1'b0; flush = 1'b0;
    check_eq("both_drain", 32'(in_ready), 32'd0);
    step();
    check_eq("both_done", 32'(done), 32'd1);

    // asynchronous reset mid-STREAM with three words still queued
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(8'h11 + 8'h22 * i); in_valid = 1'b1; step();
    end
    in_valid = 1'b0; start = 1'b1; step(); start = 1'b0;
    step();
    rst = 1'b1;
    #1;
    check_eq("rst_sys_out", 32'(sys_out), 32'd0);
    check_eq("rst_out_tag", 32'(out_tag), 32'd0);
    check_eq("rst_ready", 32'(in_ready), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    step();
    rst = 1'b0;
    step();
    check_eq("rst_release_ready", 32'(in_ready), 32'd1);
    start = 1'b1; step(); start = 1'b0;
    repeat (3) step();
    go_idle();

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 8'($urandom);
      start    = ($urandom_range(0, 15) == 0);
      flush    = ($urandom_range(0, 39) == 0);
      rst      = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0; in_valid = 1'b0; start = 1'b0; flush = 1'b0;
    repeat (3) step();
    go_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
